// File: rtl/oh_rrsel_pkg.sv
// Shared types and helpers for the oh_rrsel round-robin one-hot select arbiter.
// Holds the FSM state encoding, the minimum index width and one-hot decode.
package oh_rrsel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rr_state_e;

  // A single requester still needs a one-bit index so ports never collapse to zero width.
  localparam int MIN_IW = 1;

  // Maximum supported requester count; onehot2bin is sized for it.
  localparam int MAX_N = 32;

  function automatic logic [4:0] onehot2bin(input logic [MAX_N-1:0] v);
    logic [4:0] b;
    b = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) b = b | 5'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/oh_rrsel_rrpick.sv
// Combinational rotating-priority picker: first set bit of vec searching
// upward from ptr, wrapping modulo N back to bit 0.
module oh_rrpick
  import oh_rrsel_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : MIN_IW
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] mask;
  logic [N-1:0] hi;
  logic [N-1:0] sel;

  // Thermometer mask keeps bits at or above ptr; if none of those request,
  // the unmasked vector supplies the wrapped-around winner.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (32'(i) >= 32'(ptr));
    end
  end

  always_comb begin
    hi     = vec & mask;
    sel    = (|hi) ? hi : vec;
    onehot = sel & (~sel + {{(N-1){1'b0}}, 1'b1});
    any    = |vec;
    idx    = IW'(onehot2bin(MAX_N'(onehot)));
  end

endmodule

// File: rtl/oh_rrsel.sv
// Round-robin arbiter with packet lock producing a registered one-hot mux select.
// Handshake: a beat transfers when out_valid && out_ready; in_ready forwards out_ready to the granted source only.
module oh_rrsel
  import oh_rrsel_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : MIN_IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          last,
  input  logic          out_ready,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          out_valid,
  output logic [N-1:0]  in_ready,
  output logic          abort,
  output rr_state_e     dbg_state
);

  rr_state_e     state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          abort_q, abort_d;

  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] pick_ptr_next;
  logic          transfer;
  logic          release_now;

  // One picker serves both the IDLE grant and the back-to-back release re-pick.
  oh_rrpick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .vec    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign pick_ptr_next = (32'(pick_idx) == 32'(N - 1)) ? '0 : pick_idx + {{(IW-1){1'b0}}, 1'b1};
  assign out_valid     = |(gnt_q & req);
  assign transfer      = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    abort_d     = 1'b0;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          ptr_d   = pick_ptr_next;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A dropped request ends the packet early; a valid last beat ends it normally.
        if (!out_valid) begin
          release_now = 1'b1;
          abort_d     = 1'b1;
        end else if (transfer && last) begin
          release_now = 1'b1;
        end
        if (release_now) begin
          if (pick_any) begin
            gnt_d = pick_onehot;
            ptr_d = pick_ptr_next;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      abort_q <= abort_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = IW'(onehot2bin(MAX_N'(gnt_q)));
  assign in_ready  = gnt_q & {N{out_ready}};
  assign abort     = abort_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_oh_rrsel.sv
// Directed bench for oh_rrsel (N=5): an integer-level round-robin model checked
// every cycle, plus literal expectations for each scenario.
module tb_oh_rrsel;
  import oh_rrsel_pkg::*;

  localparam int N  = 5;
  localparam int IW = 3;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic          last;
  logic          out_ready;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          out_valid;
  logic [N-1:0]  in_ready;
  logic          abort;
  rr_state_e     dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  oh_rrsel #(.N(N), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Model: granted source as an integer (-1 when idle) and the priority pointer.
  int m_gnt   = -1;
  int m_ptr   = 0;
  bit m_abort = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_gnt   <= -1;
      m_ptr   <= 0;
      m_abort <= 1'b0;
    end else if (m_gnt < 0) begin
      m_abort <= 1'b0;
      if (pick(req, m_ptr) >= 0) begin
        m_gnt <= pick(req, m_ptr);
        m_ptr <= (pick(req, m_ptr) + 1) % N;
      end
    end else if (!req[m_gnt] || (out_ready && last)) begin
      m_abort <= !req[m_gnt];
      if (pick(req, m_ptr) >= 0) begin
        m_gnt <= pick(req, m_ptr);
        m_ptr <= (pick(req, m_ptr) + 1) % N;
      end else begin
        m_gnt <= -1;
      end
    end else begin
      m_abort <= 1'b0;
    end
  end

  // Scoreboard compare on the falling edge, away from the active edge.
  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    eg = (m_gnt >= 0) ? N'(1 << m_gnt) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_id", 32'(gnt_id), (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
    chk("out_valid", 32'(out_valid), (m_gnt >= 0) ? 32'(req[m_gnt]) : 32'd0);
    chk("in_ready", 32'(in_ready), 32'(eg & {N{out_ready}}));
    chk("abort", 32'(abort), 32'(m_abort));
    chk("state", 32'(dbg_state), (m_gnt >= 0) ? 32'(BUSY) : 32'(IDLE));
  end

  // Driver: apply inputs, let one rising edge consume them, return just after it.
  task automatic drive(input logic [N-1:0] r, input logic l, input logic rdy);
    req       = r;
    last      = l;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    last      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      drive(5'b00000, 1'b0, 1'b1);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_abort", 32'(abort), 32'd0);
    end

    // Single-beat fairness
    drive(5'b11111, 1'b1, 1'b1); chk("fair0", 32'(gnt), 32'b00001);
    drive(5'b11111, 1'b1, 1'b1); chk("fair1", 32'(gnt), 32'b00010);
    drive(5'b11111, 1'b1, 1'b1); chk("fair2", 32'(gnt), 32'b00100);
    drive(5'b11111, 1'b1, 1'b1); chk("fair3", 32'(gnt), 32'b01000);
    drive(5'b11111, 1'b1, 1'b1); chk("fair4", 32'(gnt), 32'b10000);
    drive(5'b11111, 1'b1, 1'b1); chk("fair5", 32'(gnt), 32'b00001);
    chk("fair_id", 32'(gnt_id), 32'd0);
    drive(5'b00000, 1'b1, 1'b1); chk("fair_end", 32'(gnt), 32'd0);

    // Packet lock with backpressure on source 1
    drive(5'b00110, 1'b0, 1'b1); chk("pkt_gnt", 32'(gnt), 32'b00010);
    drive(5'b00110, 1'b0, 1'b1); chk("pkt_h1", 32'(gnt), 32'b00010); chk("pkt_rdy1", 32'(in_ready), 32'b00010);
    drive(5'b00110, 1'b0, 1'b0); chk("pkt_h2", 32'(gnt), 32'b00010); chk("pkt_rdy2", 32'(in_ready), 32'b00000);
    drive(5'b00110, 1'b0, 1'b1); chk("pkt_h3", 32'(gnt), 32'b00010); chk("pkt_rdy3", 32'(in_ready), 32'b00010);
    drive(5'b00110, 1'b1, 1'b0); chk("pkt_h4", 32'(gnt), 32'b00010); chk("pkt_rdy4", 32'(in_ready), 32'b00000);
    drive(5'b00110, 1'b1, 1'b1); chk("pkt_next", 32'(gnt), 32'b00100); chk("pkt_next_id", 32'(gnt_id), 32'd2);

    // Wrap and skip: serve source 3, then ptr=4 with req 01001
    drive(5'b01100, 1'b1, 1'b1); chk("wrap_s3", 32'(gnt), 32'b01000);
    drive(5'b01001, 1'b1, 1'b1); chk("wrap_s0", 32'(gnt), 32'b00001);
    drive(5'b01001, 1'b1, 1'b1); chk("wrap_s3b", 32'(gnt), 32'b01000); chk("wrap_id", 32'(gnt_id), 32'd3);

    // Abort: source 2 drops req after one non-last beat while source 4 waits
    drive(5'b01100, 1'b1, 1'b1); chk("ab_s2", 32'(gnt), 32'b00100);
    drive(5'b10100, 1'b0, 1'b1); chk("ab_hold", 32'(gnt), 32'b00100); chk("ab_pre", 32'(abort), 32'd0);
    drive(5'b10000, 1'b0, 1'b1); chk("ab_pulse", 32'(abort), 32'd1); chk("ab_gnt", 32'(gnt), 32'b10000);
    drive(5'b10000, 1'b0, 1'b1); chk("ab_clear", 32'(abort), 32'd0); chk("ab_gnt2", 32'(gnt), 32'b10000);

    // Mid-packet asynchronous reset on source 3
    drive(5'b11000, 1'b1, 1'b1); chk("mr_s3", 32'(gnt), 32'b01000);
    drive(5'b01000, 1'b0, 1'b1); chk("mr_hold", 32'(gnt), 32'b01000);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_gnt0", 32'(gnt), 32'd0);
    chk("mr_ov0", 32'(out_valid), 32'd0);
    chk("mr_rdy0", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    req   = 5'b01001;
    reset = 1'b0;
    drive(5'b01001, 1'b1, 1'b1); chk("mr_first", 32'(gnt), 32'b00001);
    drive(5'b01001, 1'b1, 1'b1); chk("mr_second", 32'(gnt), 32'b01000);
    drive(5'b00000, 1'b1, 1'b1);
    drive(5'b00000, 1'b0, 1'b0); chk("final_idle", 32'(gnt), 32'd0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
